// File: rtl/hazard_sched.sv
// hazard_sched: central hazard controller and scheduler for the 5-stage MIPS pipeline.
// Detects load-use hazards, taken branches and outstanding multi-cycle data-memory
// accesses, and drives the PC / pipeline-register load and flush controls.
// Also drives the EX-stage forwarding selects.
// A watchdog moves the block to a sticky FAULT state when memory never answers.
// Optional feature macro: STALL_PERF_EN builds the saturating stall-cycle counter;
// without it stall_cnt is tied to zero.

module hazard_sched #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             branch_taken,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_rd,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_load,
    output logic             if_id_load,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_freeze,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        FAULT   = 2'd2
    } stateT;

    localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

    stateT      state;
    stateT      nextState;
    logic [7:0] waitCnt;
    logic [7:0] nextWaitCnt;

    logic       loadUse;
    logic       memStall;

    logic       pcLoadC;
    logic       ifIdLoadC;
    logic       ifIdFlushC;
    logic       idExFlushC;
    logic       freezeC;
    logic       timeoutC;
    logic [1:0] fwdAC;
    logic [1:0] fwdBC;

    // A load in EX whose destination feeds the instruction in ID needs one bubble.
    assign loadUse  = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));
    // Memory request in flight that has not completed this cycle.
    assign memStall = dmem_req && !dmem_ready;

    // State register and memory-wait watchdog counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            waitCnt <= 8'd0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
        end
    end

    // Next-state logic and Mealy pipeline controls, prioritised memory stall > load-use > branch.
    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        pcLoadC     = 1'b1;
        ifIdLoadC   = 1'b1;
        ifIdFlushC  = 1'b0;
        idExFlushC  = 1'b0;
        freezeC     = 1'b0;
        timeoutC    = 1'b0;
        case (state)
            RUN: begin
                if (memStall) begin
                    pcLoadC     = 1'b0;
                    ifIdLoadC   = 1'b0;
                    freezeC     = 1'b1;
                    nextWaitCnt = 8'd1;
                    nextState   = (WAIT_MAX <= 8'd1) ? FAULT : MEMWAIT;
                end else if (loadUse) begin
                    pcLoadC    = 1'b0;
                    ifIdLoadC  = 1'b0;
                    idExFlushC = 1'b1;
                end else if (branch_taken) begin
                    ifIdFlushC = 1'b1;
                end
            end
            MEMWAIT: begin
                if (dmem_ready) begin
                    nextState   = RUN;
                    nextWaitCnt = 8'd0;
                end else begin
                    pcLoadC     = 1'b0;
                    ifIdLoadC   = 1'b0;
                    freezeC     = 1'b1;
                    nextWaitCnt = waitCnt + 8'd1;
                    if ((waitCnt + 8'd1) >= WAIT_MAX) begin
                        nextState = FAULT;
                    end
                end
            end
            FAULT: begin
                pcLoadC   = 1'b0;
                ifIdLoadC = 1'b0;
                freezeC   = 1'b1;
                timeoutC  = 1'b1;
            end
            default: begin
                nextState   = RUN;
                nextWaitCnt = 8'd0;
            end
        endcase
    end

    // EX-stage forwarding selects; the younger EX/MEM result wins over MEM/WB, $0 never forwards.
    always_comb begin
        fwdAC = 2'b00;
        fwdBC = 2'b00;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs)) begin
            fwdAC = 2'b10;
        end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs)) begin
            fwdAC = 2'b01;
        end
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rt)) begin
            fwdBC = 2'b10;
        end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rt)) begin
            fwdBC = 2'b01;
        end
    end

    // While reset is held the pipeline is frozen and nothing loads or forwards.
    assign pc_load     = rst & pcLoadC;
    assign if_id_load  = rst & ifIdLoadC;
    assign if_id_flush = rst & ifIdFlushC;
    assign id_ex_flush = rst & idExFlushC;
    assign pipe_freeze = ~rst | freezeC;
    assign fwd_a       = rst ? fwdAC : 2'b00;
    assign fwd_b       = rst ? fwdBC : 2'b00;
    assign timeout     = rst & timeoutC;

`ifdef STALL_PERF_EN
    logic [CNT_W-1:0] stallCnt;

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt <= '0;
        end else if (!pcLoadC && (stallCnt != '1)) begin
            stallCnt <= stallCnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = stallCnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// tb_hazard_sched: self-checking bench for hazard_sched.
// Directed scenarios compare against hand-derived constants; a randomized phase
// compares every cycle against a behavioural model of the scheduling rules.

module tb_hazard_sched;

    localparam int MEM_WAIT_MAX = 15;
    localparam int CNT_W        = 16;
`ifdef STALL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Control vector order: pc_load, if_id_load, if_id_flush, id_ex_flush, pipe_freeze, fwd_a, fwd_b, timeout
    localparam logic [9:0] CTL_RESET  = 10'b00001_00_00_0;
    localparam logic [9:0] CTL_NORMAL = 10'b11000_00_00_0;
    localparam logic [9:0] CTL_BRANCH = 10'b11100_00_00_0;
    localparam logic [9:0] CTL_BUBBLE = 10'b00010_00_00_0;
    localparam logic [9:0] CTL_FREEZE = 10'b00001_00_00_0;
    localparam logic [9:0] CTL_FAULT  = 10'b00001_00_00_1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       id_rs = '0;
    logic [4:0]       id_rt = '0;
    logic             branch_taken = 1'b0;
    logic             ex_mem_read = 1'b0;
    logic [4:0]       ex_rs = '0;
    logic [4:0]       ex_rt = '0;
    logic             mem_reg_write = 1'b0;
    logic [4:0]       mem_rd = '0;
    logic             wb_reg_write = 1'b0;
    logic [4:0]       wb_rd = '0;
    logic             dmem_req = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             pc_load;
    logic             if_id_load;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             pipe_freeze;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             timeout;
    logic [CNT_W-1:0] stall_cnt;

    int passCount  = 0;
    int checkCount = 0;

    // Behavioural model: is a memory access outstanding, for how many cycles, has the watchdog fired.
    bit mWaiting;
    int mWaitCycles;
    bit mFault;
    int mStall;

    hazard_sched #(
        .MEM_WAIT_MAX(MEM_WAIT_MAX),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .branch_taken (branch_taken),
        .ex_mem_read  (ex_mem_read),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .mem_reg_write(mem_reg_write),
        .mem_rd       (mem_rd),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .pc_load      (pc_load),
        .if_id_load   (if_id_load),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .pipe_freeze  (pipe_freeze),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .timeout      (timeout),
        .stall_cnt    (stall_cnt)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    function automatic logic [9:0] observed();
        return {pc_load, if_id_load, if_id_flush, id_ex_flush, pipe_freeze,
                fwd_a, fwd_b, timeout};
    endfunction

    function automatic logic [1:0] fwdFor(input logic [4:0] src);
        if (mem_reg_write && mem_rd != 5'd0 && mem_rd == src) return 2'b10;
        if (wb_reg_write && wb_rd != 5'd0 && wb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [9:0] predictCtl();
        logic [1:0] fa;
        logic [1:0] fb;
        bit         lu;
        if (!rst) return CTL_RESET;
        fa = fwdFor(ex_rs);
        fb = fwdFor(ex_rt);
        lu = ex_mem_read && ex_rt != 5'd0 && (ex_rt == id_rs || ex_rt == id_rt);
        if (mFault) return {5'b00001, fa, fb, 1'b1};
        if (mWaiting) return {(dmem_ready ? 5'b11000 : 5'b00001), fa, fb, 1'b0};
        if (dmem_req && !dmem_ready) return {5'b00001, fa, fb, 1'b0};
        if (lu) return {5'b00010, fa, fb, 1'b0};
        if (branch_taken) return {5'b11100, fa, fb, 1'b0};
        return {5'b11000, fa, fb, 1'b0};
    endfunction

    task automatic resetModel();
        mWaiting    = 1'b0;
        mWaitCycles = 0;
        mFault      = 1'b0;
        mStall      = 0;
    endtask

    task automatic clearInputs();
        id_rs = '0; id_rt = '0; branch_taken = 1'b0; ex_mem_read = 1'b0;
        ex_rs = '0; ex_rt = '0; mem_reg_write = 1'b0; mem_rd = '0;
        wb_reg_write = 1'b0; wb_rd = '0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // Advance one clock edge and move the model along with it.
    task automatic tick();
        logic [9:0] ctl;
        ctl = predictCtl();
        @(posedge clk);
        if (rst) begin
            if (PERF && !ctl[9] && mStall < (2 ** CNT_W) - 1) mStall++;
            if (mFault) begin
                mFault = 1'b1;
            end else if (mWaiting) begin
                if (dmem_ready) begin
                    mWaiting    = 1'b0;
                    mWaitCycles = 0;
                end else begin
                    mWaitCycles++;
                    if (mWaitCycles >= MEM_WAIT_MAX) begin
                        mWaiting = 1'b0;
                        mFault   = 1'b1;
                    end
                end
            end else if (dmem_req && !dmem_ready) begin
                mWaitCycles = 1;
                if (mWaitCycles >= MEM_WAIT_MAX) mFault = 1'b1;
                else mWaiting = 1'b1;
            end
        end
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0;
        clearInputs();
        resetModel();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        resetModel();
        dmem_req = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd4; ex_rs = 5'd4; ex_rt = 5'd4;
        branch_taken = 1'b1;
        #2;
        checkCount++;
        if (observed() !== CTL_RESET) $display("[TB] FAIL reset_ctl: got %b expected %b", observed(), CTL_RESET);
        else passCount++;
        checkCount++;
        if (stall_cnt !== '0) $display("[TB] FAIL reset_stall: got %0d expected 0", stall_cnt);
        else passCount++;
        @(posedge clk);
        #1;
        clearInputs();
        rst = 1'b1;
    endtask

    task automatic test_load_use();
        doReset();
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_rt = 5'd2;
        @(negedge clk);
        checkCount++;
        if (observed() !== CTL_BUBBLE) $display("[TB] FAIL lu_bubble: got %b expected %b", observed(), CTL_BUBBLE);
        else passCount++;
        tick();
        ex_mem_read = 1'b0;
        @(negedge clk);
        checkCount++;
        if (observed() !== CTL_NORMAL) $display("[TB] FAIL lu_after: got %b expected %b", observed(), CTL_NORMAL);
        else passCount++;
        checkCount++;
        if (stall_cnt !== CNT_W'(PERF ? 1 : 0)) $display("[TB] FAIL lu_stall: got %0d expected %0d", stall_cnt, PERF ? 1 : 0);
        else passCount++;
        tick();
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        @(negedge clk);
        checkCount++;
        if (observed() !== CTL_NORMAL) $display("[TB] FAIL lu_reg0: got %b expected %b", observed(), CTL_NORMAL);
        else passCount++;
        tick();
        ex_rt = 5'd9; id_rs = 5'd1; id_rt = 5'd9;
        @(negedge clk);
        checkCount++;
        if (id_ex_flush !== 1'b1 || pc_load !== 1'b0) $display("[TB] FAIL lu_rt: got flush=%b pc=%b expected flush=1 pc=0", id_ex_flush, pc_load);
        else passCount++;
        tick();
    endtask

    task automatic test_forwarding();
        doReset();
        ex_rs = 5'd5; mem_rd = 5'd5; wb_rd = 5'd5; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
        @(negedge clk);
        checkCount++;
        if (fwd_a !== 2'b10) $display("[TB] FAIL fwd_mem: got %b expected 10", fwd_a);
        else passCount++;
        tick();
        mem_reg_write = 1'b0;
        @(negedge clk);
        checkCount++;
        if (fwd_a !== 2'b01) $display("[TB] FAIL fwd_wb: got %b expected 01", fwd_a);
        else passCount++;
        tick();
        mem_reg_write = 1'b1; ex_rs = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
        @(negedge clk);
        checkCount++;
        if (fwd_a !== 2'b00) $display("[TB] FAIL fwd_reg0: got %b expected 00", fwd_a);
        else passCount++;
        tick();
        ex_rt = 5'd7; wb_rd = 5'd7; mem_rd = 5'd6; ex_rs = 5'd6;
        @(negedge clk);
        checkCount++;
        if ({fwd_a, fwd_b} !== 4'b1001) $display("[TB] FAIL fwd_both: got %b expected 1001", {fwd_a, fwd_b});
        else passCount++;
        tick();
    endtask

    task automatic test_branch();
        doReset();
        branch_taken = 1'b1;
        @(negedge clk);
        checkCount++;
        if (observed() !== CTL_BRANCH) $display("[TB] FAIL branch: got %b expected %b", observed(), CTL_BRANCH);
        else passCount++;
        tick();
        branch_taken = 1'b0;
        @(negedge clk);
        checkCount++;
        if (observed() !== CTL_NORMAL) $display("[TB] FAIL branch_after: got %b expected %b", observed(), CTL_NORMAL);
        else passCount++;
        tick();
        branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd3; id_rt = 5'd3;
        @(negedge clk);
        checkCount++;
        if (observed() !== CTL_BUBBLE) $display("[TB] FAIL branch_lu: got %b expected %b", observed(), CTL_BUBBLE);
        else passCount++;
        tick();
    endtask

    task automatic test_memwait();
        doReset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkCount++;
            if (observed() !== CTL_FREEZE) $display("[TB] FAIL memwait_freeze%0d: got %b expected %b", i, observed(), CTL_FREEZE);
            else passCount++;
            tick();
        end
        dmem_ready = 1'b1;
        @(negedge clk);
        checkCount++;
        if (observed() !== CTL_NORMAL) $display("[TB] FAIL memwait_release: got %b expected %b", observed(), CTL_NORMAL);
        else passCount++;
        tick();
        dmem_req = 1'b0; branch_taken = 1'b1;
        @(negedge clk);
        checkCount++;
        if (observed() !== CTL_BRANCH) $display("[TB] FAIL memwait_run: got %b expected %b", observed(), CTL_BRANCH);
        else passCount++;
        checkCount++;
        if (stall_cnt !== CNT_W'(PERF ? 3 : 0)) $display("[TB] FAIL memwait_stall: got %0d expected %0d", stall_cnt, PERF ? 3 : 0);
        else passCount++;
        tick();
    endtask

    task automatic test_timeout();
        int badCycles;
        doReset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        badCycles = 0;
        for (int i = 0; i < MEM_WAIT_MAX; i++) begin
            @(negedge clk);
            if (observed() !== CTL_FREEZE) badCycles++;
            tick();
        end
        checkCount++;
        if (badCycles != 0) $display("[TB] FAIL timeout_wait: got %0d bad cycles expected 0", badCycles);
        else passCount++;
        @(negedge clk);
        checkCount++;
        if (observed() !== CTL_FAULT) $display("[TB] FAIL timeout_fault: got %b expected %b", observed(), CTL_FAULT);
        else passCount++;
        tick();
        dmem_req = 1'b0; dmem_ready = 1'b1;
        @(negedge clk);
        checkCount++;
        if (observed() !== CTL_FAULT) $display("[TB] FAIL timeout_sticky: got %b expected %b", observed(), CTL_FAULT);
        else passCount++;
        tick();
        checkCount++;
        if (stall_cnt !== CNT_W'(PERF ? MEM_WAIT_MAX + 2 : 0)) $display("[TB] FAIL timeout_stall: got %0d expected %0d", stall_cnt, PERF ? MEM_WAIT_MAX + 2 : 0);
        else passCount++;
        #1;
        rst = 1'b0;
        resetModel();
        #1;
        checkCount++;
        if ({observed(), stall_cnt} !== {CTL_RESET, {CNT_W{1'b0}}}) $display("[TB] FAIL timeout_rst: got %b/%0d expected %b/0", observed(), stall_cnt, CTL_RESET);
        else passCount++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkCount++;
        if (observed() !== CTL_NORMAL) $display("[TB] FAIL timeout_recover: got %b expected %b", observed(), CTL_NORMAL);
        else passCount++;
        tick();
    endtask

    task automatic test_async_reset();
        doReset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        tick();
        tick();
        #1;
        rst = 1'b0;
        resetModel();
        #1;
        checkCount++;
        if (observed() !== CTL_RESET) $display("[TB] FAIL async_rst: got %b expected %b", observed(), CTL_RESET);
        else passCount++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        dmem_req = 1'b0;
        @(negedge clk);
        checkCount++;
        if (observed() !== CTL_NORMAL) $display("[TB] FAIL async_after: got %b expected %b", observed(), CTL_NORMAL);
        else passCount++;
        tick();
    endtask

    task automatic test_random();
        logic [9:0]       expCtl;
        logic [CNT_W-1:0] expStall;
        doReset();
        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(0, 99) != 0);
            if (!rst) resetModel();
            id_rs         = 5'($urandom_range(0, 3));
            id_rt         = 5'($urandom_range(0, 3));
            ex_rs         = 5'($urandom_range(0, 3));
            ex_rt         = 5'($urandom_range(0, 3));
            mem_rd        = 5'($urandom_range(0, 3));
            wb_rd         = 5'($urandom_range(0, 3));
            branch_taken  = ($urandom_range(0, 3) == 0);
            ex_mem_read   = ($urandom_range(0, 2) == 0);
            mem_reg_write = $urandom_range(0, 1) == 1;
            wb_reg_write  = $urandom_range(0, 1) == 1;
            dmem_req      = ($urandom_range(0, 2) == 0);
            dmem_ready    = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            expCtl   = predictCtl();
            expStall = mStall[CNT_W-1:0];
            checkCount++;
            if (observed() !== expCtl) $display("[TB] FAIL rand_ctl cycle %0d: got %b expected %b", i, observed(), expCtl);
            else passCount++;
            checkCount++;
            if (stall_cnt !== expStall) $display("[TB] FAIL rand_stall cycle %0d: got %0d expected %0d", i, stall_cnt, expStall);
            else passCount++;
            tick();
        end
        rst = 1'b1;
    endtask

    // Run every scenario in sequence, then report.
    initial begin
        resetModel();
        #1;
        test_reset();
        test_load_use();
        test_forwarding();
        test_branch();
        test_memwait();
        test_timeout();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
